// File: rtl/demux_1to3_32bit_pkg.sv
// Shared constants for the 1-to-3 word distributor: select encodings, port indices, entry sizing.
package demux_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned NUM_OUT = 3;

    // Select encodings; SEL_OUT2 stands for the whole 2'b1? group (only bit 1 is decoded)
    localparam logic [SEL_W-1:0] SEL_OUT0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL_OUT1 = 2'b01;
    localparam logic [SEL_W-1:0] SEL_OUT2 = 2'b10;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;
    localparam int unsigned PORT2 = 2;

    // Queue entry holds {select, data}
    function automatic int unsigned entry_width(input int unsigned data_w);
        return data_w + SEL_W;
    endfunction

    // Select to one-hot destination; an unknown select falls through to all-x
    function automatic logic [NUM_OUT-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] onehot;
        if (sel == SEL_OUT0)
            onehot = 3'b001;
        else if (sel == SEL_OUT1)
            onehot = 3'b010;
        else if (sel[1] == SEL_OUT2[1])
            onehot = 3'b100;
        else
            onehot = 3'bxxx;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_1to3_32bit_if.sv
// Producer/consumer bundle for the 1-to-3 distributor.
interface demux_1to3_32bit_if
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH     = DATA_W,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     In;
    logic [SEL_W-1:0]     Select;
    logic                 In_Valid;
    logic                 In_Ready;
    logic [WIDTH-1:0]     Out0;
    logic [WIDTH-1:0]     Out1;
    logic [WIDTH-1:0]     Out2;
    logic [NUM_OUT-1:0]   Out_Valid;
    logic [NUM_OUT-1:0]   Out_Ready;
    logic [CNT_WIDTH-1:0] Count0;
    logic [CNT_WIDTH-1:0] Count1;
    logic [CNT_WIDTH-1:0] Count2;

    modport master (
        output In, Select, In_Valid, Out_Ready,
        input  In_Ready, Out0, Out1, Out2, Out_Valid, Count0, Count1, Count2
    );

    modport slave (
        input  In, Select, In_Valid, Out_Ready,
        output In_Ready, Out0, Out1, Out2, Out_Valid, Count0, Count1, Count2
    );
endinterface

// File: rtl/demux_1to3_32bit_sync_fifo.sv
// Generic synchronous FIFO; full blocks push even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_occ == CNT_W'(DEPTH));
    assign o_empty = (r_occ == CNT_W'(0));
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage write; contents are don't-care until pushed, so no reset
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/demux_1to3_32bit.sv
// Buffered 1-to-3 word distributor: queue words with their select, present the head to one consumer.
module demux_1to3_32bit
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH     = DATA_W,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    demux_1to3_32bit_if.slave  bus
);
    localparam int unsigned ENT_W = entry_width(WIDTH);

    logic [ENT_W-1:0]     w_head;
    logic [WIDTH-1:0]     w_head_data;
    logic [SEL_W-1:0]     w_head_sel;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_OUT-1:0]   w_out_valid;
    logic [WIDTH-1:0]     w_out_data;
    logic [WIDTH-1:0]     r_hold;
    logic [CNT_WIDTH-1:0] r_count0;
    logic [CNT_WIDTH-1:0] r_count1;
    logic [CNT_WIDTH-1:0] r_count2;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.Select, bus.In}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_head_data = w_head[WIDTH-1:0];
    assign w_head_sel  = w_head[ENT_W-1:WIDTH];
    assign w_push      = bus.In_Valid & ~w_full;
    assign w_pop       = |(w_out_valid & bus.Out_Ready);

    // Destination decode and data select; empty queue shows the last delivered word
    always_comb begin
        w_out_valid = '0;
        w_out_data  = r_hold;
        if (!w_empty) begin
            w_out_valid = sel_decode(w_head_sel);
            w_out_data  = w_head_data;
        end
    end

    // Remember the word leaving the queue so data ports hold it while empty
    always_ff @(posedge Clock) begin
        if (Reset)
            r_hold <= '0;
        else if (w_pop)
            r_hold <= w_head_data;
    end

    // Per-port delivered-word counters, wrapping at 2^CNT_WIDTH
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count0 <= '0;
            r_count1 <= '0;
            r_count2 <= '0;
        end else if (w_pop) begin
            if (w_out_valid[PORT0])
                r_count0 <= r_count0 + CNT_WIDTH'(1);
            if (w_out_valid[PORT1])
                r_count1 <= r_count1 + CNT_WIDTH'(1);
            if (w_out_valid[PORT2])
                r_count2 <= r_count2 + CNT_WIDTH'(1);
        end
    end

    assign bus.In_Ready  = ~w_full;
    assign bus.Out_Valid = w_out_valid;
    assign bus.Out0      = w_out_data;
    assign bus.Out1      = w_out_data;
    assign bus.Out2      = w_out_data;
    assign bus.Count0    = r_count0;
    assign bus.Count1    = r_count1;
    assign bus.Count2    = r_count2;
endmodule

// File: tb/tb_demux_1to3_32bit.sv
// Directed bench for demux_1to3_32bit with a queue-based reference model.
module tb_demux_1to3_32bit;

    localparam int DEPTH = 2;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    exp_t        q_exp[$];
    logic [7:0]  m_cnt [3];
    logic [31:0] m_last;

    demux_1to3_32bit_if #(.WIDTH(32), .CNT_WIDTH(8)) bus ();

    demux_1to3_32bit #(
        .WIDTH     (32),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (8)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int port_of(input logic [1:0] sel);
        if (sel == 2'b00) return 0;
        if (sel == 2'b01) return 1;
        return 2;
    endfunction

    function automatic logic [2:0] onehot_of(input logic [1:0] sel);
        logic [2:0] v;
        v = 3'b000;
        v[port_of(sel)] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [2:0] r);
        bus.In_Valid  = v;
        bus.Select    = s;
        bus.In        = d;
        bus.Out_Ready = r;
    endtask

    // One clock: check DUT against model mid-cycle, then advance model with the coming edge
    task automatic cycle();
        logic [2:0]  exp_v;
        logic [31:0] exp_d;
        logic        rdy;
        exp_t        h;
        exp_t        e;
        @(negedge clk);
        rdy = (q_exp.size() < DEPTH);
        if (q_exp.size() == 0) begin
            exp_v = 3'b000;
            exp_d = m_last;
        end else begin
            exp_v = onehot_of(q_exp[0].sel);
            exp_d = q_exp[0].data;
        end
        chk("in_ready",  64'(bus.In_Ready),  64'(rdy));
        chk("out_valid", 64'(bus.Out_Valid), 64'(exp_v));
        chk("out0",      64'(bus.Out0),      64'(exp_d));
        chk("out1",      64'(bus.Out1),      64'(exp_d));
        chk("out2",      64'(bus.Out2),      64'(exp_d));
        chk("count0",    64'(bus.Count0),    64'(m_cnt[0]));
        chk("count1",    64'(bus.Count1),    64'(m_cnt[1]));
        chk("count2",    64'(bus.Count2),    64'(m_cnt[2]));
        if (rst) begin
            q_exp.delete();
            m_cnt[0] = 8'd0;
            m_cnt[1] = 8'd0;
            m_cnt[2] = 8'd0;
            m_last   = 32'd0;
        end else begin
            if (q_exp.size() > 0 && (exp_v & bus.Out_Ready) != 3'b000) begin
                h = q_exp.pop_front();
                m_last = h.data;
                m_cnt[port_of(h.sel)] = m_cnt[port_of(h.sel)] + 8'd1;
            end
            if (bus.In_Valid && rdy) begin
                e.sel  = bus.Select;
                e.data = bus.In;
                q_exp.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_cnt[0] = 8'd0;
        m_cnt[1] = 8'd0;
        m_cnt[2] = 8'd0;
        m_last   = 32'd0;
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        repeat (5) cycle();
        chk("idle_ready",  64'(bus.In_Ready),  64'(1'b1));
        chk("idle_valid",  64'(bus.Out_Valid), 64'(3'b000));
        chk("idle_count0", 64'(bus.Count0),    64'(8'd0));

        // Single word to port 1, consumers ready
        drive(1'b1, 2'b01, 32'hDEADBEEF, 3'b111);
        cycle();
        drive(1'b0, 2'b00, 32'd0, 3'b111);
        chk("beef_valid", 64'(bus.Out_Valid), 64'(3'b010));
        chk("beef_data",  64'(bus.Out1),      64'(32'hDEADBEEF));
        cycle();
        cycle();
        chk("beef_count1", 64'(bus.Count1), 64'(8'd1));
        chk("beef_count0", 64'(bus.Count0), 64'(8'd0));

        // Select 10 and 11 both go to port 2
        drive(1'b1, 2'b10, 32'h2222_0010, 3'b111);
        cycle();
        drive(1'b1, 2'b11, 32'h2222_0011, 3'b111);
        cycle();
        drive(1'b0, 2'b00, 32'd0, 3'b111);
        repeat (3) cycle();
        chk("sel1x_count2", 64'(bus.Count2), 64'(8'd2));

        // Fill the queue with consumers stalled
        drive(1'b1, 2'b00, 32'hAAAA_0000, 3'b000);
        cycle();
        drive(1'b1, 2'b01, 32'hBBBB_0001, 3'b000);
        cycle();
        drive(1'b1, 2'b00, 32'hCCCC_0000, 3'b000);
        chk("full_ready", 64'(bus.In_Ready),  64'(1'b0));
        chk("full_head",  64'(bus.Out_Valid), 64'(3'b001));
        cycle();
        drive(1'b1, 2'b00, 32'hCCCC_0000, 3'b010);
        repeat (2) cycle();
        chk("wrong_ready_nopop", 64'(bus.Out_Valid), 64'(3'b001));
        drive(1'b1, 2'b00, 32'hCCCC_0000, 3'b001);
        cycle();
        chk("after_pop_ready", 64'(bus.In_Ready), 64'(1'b1));
        cycle();
        drive(1'b0, 2'b00, 32'd0, 3'b111);
        repeat (4) cycle();

        // Reset, then stream 300 words to port 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'b00, 32'h1000_0000 + 32'(i), 3'b001);
            cycle();
        end
        drive(1'b0, 2'b00, 32'd0, 3'b001);
        repeat (3) cycle();
        chk("stream_count0_wrap", 64'(bus.Count0), 64'(8'd44));

        // Reset with two words queued for port 2
        drive(1'b1, 2'b10, 32'h5555_0001, 3'b000);
        cycle();
        drive(1'b1, 2'b11, 32'h5555_0002, 3'b000);
        cycle();
        drive(1'b0, 2'b00, 32'd0, 3'b000);
        chk("prerst_valid", 64'(bus.Out_Valid), 64'(3'b100));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("postrst_valid",  64'(bus.Out_Valid), 64'(3'b000));
        chk("postrst_count0", 64'(bus.Count0),    64'(8'd0));
        chk("postrst_count2", 64'(bus.Count2),    64'(8'd0));
        drive(1'b0, 2'b00, 32'd0, 3'b111);
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to3_32bit.md
Name: demux_1to3_32bit

Overview:
- Buffered 1-to-3 word distributor. It is the inverse of the 3-to-1 32-bit mux used on the datapath.
- Accepts a 32-bit word and a 2-bit Select through a valid/ready handshake, queues it, and delivers it to exactly one of three consumer ports.
- Used where one producer feeds three downstream units that stall independently.
- Keeps a delivered-word count for each output for debug and verification.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, queue entries (power of two, ≥2).
- CNT_WIDTH, 8, width of each delivered-word counter.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- In  input  WIDTH  input data word.
- Select  input  2  destination: 00→Out0, 01→Out1, 10/11→Out2.
- In_Valid  input  1  producer offers In/Select this cycle.
- In_Ready  output  1  block can accept a word this cycle.
- Out0, Out1, Out2  output  WIDTH  data to each consumer (all carry the head word).
- Out_Valid  output  3  bit k: head word is destined for port k.
- Out_Ready  input  3  bit k: consumer k accepts this cycle.
- Count0, Count1, Count2  output  CNT_WIDTH  words delivered per port.

Behaviour:
- Reset (Reset=1 at a rising edge):
  - Queue emptied; buffered words discarded, including mid-transfer.
  - Out_Valid=000, Out0/1/2=0, Count0/1/2=0.
  - In_Ready=1 from the first cycle after reset is released.
  - Reset overrides any push or pop in the same cycle.
- Push:
  - Occurs when In_Valid & In_Ready at a rising edge.
  - {Select,In} is written at the tail.
  - In_Ready = (occupancy < DEPTH). It depends on registered state only, with no combinational path from Out_Ready.
  - When full, In_Ready=0 even if a pop happens in the same cycle.
- Head presentation:
  - When the queue is non-empty, Out0/1/2 all equal the head data.
  - Exactly one Out_Valid bit is set, decoded from the head Select: 00→bit0, 01→bit1, 1?→bit2.
  - When empty, Out_Valid=000 and the data ports hold their last value.
- Latency:
  - A word pushed into an empty queue at edge N is visible with Out_Valid at cycle N+1. There is no same-cycle bypass.
  - Throughput is 1 word/cycle when consumers are ready.
- Pop:
  - Occurs when Out_Valid[k] & Out_Ready[k] at a rising edge.
  - Removes the head and increments Count_k by 1, wrapping modulo 2^CNT_WIDTH (255→0).
  - Out_Ready bits for non-selected ports are ignored.
  - A blocked head stalls all ports; there is no reordering.
- Simultaneous push and pop:
  - Occupancy is unchanged and order is preserved.
  - If empty, only a push can occur.
- Pointers:
  - Read and write pointers wrap modulo DEPTH.
  - Occupancy counter ranges 0..DEPTH; full and empty are derived from it.
- Data integrity:
  - Words leave in arrival order, each exactly once.
  - Select is captured with its data, so later Select changes do not affect queued words.
- X handling: an unknown head Select drives Out_Valid=xxx in simulation only.

Decomposition:
- Package demux_pkg holds:
  - the Select encodings SEL_OUT0=2'b00, SEL_OUT1=2'b01, SEL_OUT2 (2'b1?);
  - the port index constants;
  - the entry width, WIDTH+2.
- One sub-module, sync_fifo, is a generic synchronous FIFO (parameters width and depth) with push/pop/full/empty/head.
- The top level adds the Select decode, the valid/ready gating and the three counters.

Test Plan:
- Reset then idle: In_Valid=0 for 5 cycles → In_Ready=1, Out_Valid=000, Count0..2=0.
- Push 32'hDEADBEEF with Select=01 and Out_Ready=111 → Out_Valid=010 one cycle later, Out1=32'hDEADBEEF, popped that cycle, Count1=1, others 0.
- Select=10 then 11 with all consumers ready → both words go to Out2, Count2=2.
- Fill queue:
  - Out_Ready=000; push A(sel00), B(sel01), C(sel00) on consecutive cycles.
  - Expect In_Ready=0 after B, C held off by the producer, head A on Out_Valid=001.
  - Raise Out_Ready[1] only → no pop.
  - Raise Out_Ready[0] → A pops, In_Ready=1 next cycle.
- Streaming 300 words to port 0 with Out_Ready[0]=1 → one pop per cycle after the first, data in order, Count0 wraps to 44.
- Reset asserted with 2 words queued and Out_Valid=100 → next cycle Out_Valid=000 and all counts 0; the queued words never appear.
